// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN parameter loader: controller states and chain length.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_LOADED    = 3'd3,
        ST_EVAL      = 3'd4
    } state_e;

    function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
        return neurons * (inputs + bias_bits);
    endfunction

endpackage

// File: rtl/param_serializer.sv
// Byte latch and MSB-first shifter feeding the neuron parameter chain, with a saturating bit count.
module param_serializer #(
    parameter int CHAIN_BITS = 44,
    localparam int CW = $clog2(CHAIN_BITS + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_shift,
    output logic       o_bit,
    output logic       o_byte_last,
    output logic       o_chain_last
);

    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic [CW-1:0] r_count;

    // The shifter is kept at zero outside a shift burst so o_bit is quiet when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_count   <= '0;
        end else if (i_clear) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_count   <= '0;
        end else if (i_load) begin
            r_shift   <= i_byte;
            r_bit_idx <= 3'd0;
        end else if (i_shift) begin
            r_shift   <= o_chain_last ? 8'h00 : {r_shift[6:0], 1'b0};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_count != CW'(CHAIN_BITS)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_bit        = r_shift[7];
    assign o_byte_last  = (r_bit_idx == 3'd7);
    assign o_chain_last = (r_count == CW'(CHAIN_BITS - 1));

endmodule

// File: rtl/bnn_param_loader.sv
// Loads a BNN neuron parameter chain from a byte stream, then runs single-vector inferences.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int NEURONS   = 4,
    parameter int INPUTS    = 8,
    parameter int BIAS_BITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_load,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               setup,
    output logic               param_bit,
    output logic               loaded,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INPUTS-1:0]  in_data,
    output logic [INPUTS-1:0]  neuron_inputs,
    input  logic [NEURONS-1:0] axons,
    output logic               out_valid,
    output logic [NEURONS-1:0] out_data
);

    localparam int CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);

    state_e             r_state;
    logic               r_byte_ready;
    logic               r_setup;
    logic               r_loaded;
    logic               r_in_open;
    logic               r_out_valid;
    logic [INPUTS-1:0]  r_neuron_inputs;
    logic [NEURONS-1:0] r_out_data;

    logic w_clear;
    logic w_load;
    logic w_shift;
    logic w_bit;
    logic w_byte_last;
    logic w_chain_last;

    assign w_clear = start_load && ((r_state == ST_IDLE) || (r_state == ST_LOADED));
    assign w_load  = (r_state == ST_WAIT_BYTE) && byte_valid && r_byte_ready;
    assign w_shift = (r_state == ST_SHIFT);

    param_serializer #(.CHAIN_BITS(CHAIN_BITS)) u_ser (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_load       (w_load),
        .i_byte       (byte_data),
        .i_shift      (w_shift),
        .o_bit        (w_bit),
        .o_byte_last  (w_byte_last),
        .o_chain_last (w_chain_last)
    );

    // Controller: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_byte_ready    <= 1'b0;
            r_setup         <= 1'b0;
            r_loaded        <= 1'b0;
            r_in_open       <= 1'b0;
            r_out_valid     <= 1'b0;
            r_neuron_inputs <= '0;
            r_out_data      <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_load) begin
                        r_state      <= ST_WAIT_BYTE;
                        r_byte_ready <= 1'b1;
                        r_loaded     <= 1'b0;
                    end
                end
                ST_WAIT_BYTE: begin
                    if (byte_valid && r_byte_ready) begin
                        r_state      <= ST_SHIFT;
                        r_byte_ready <= 1'b0;
                        r_setup      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_chain_last) begin
                        r_state   <= ST_LOADED;
                        r_setup   <= 1'b0;
                        r_loaded  <= 1'b1;
                        r_in_open <= 1'b1;
                    end else if (w_byte_last) begin
                        r_state      <= ST_WAIT_BYTE;
                        r_setup      <= 1'b0;
                        r_byte_ready <= 1'b1;
                    end
                end
                ST_LOADED: begin
                    // A reload request outranks an offered vector.
                    if (start_load) begin
                        r_state      <= ST_WAIT_BYTE;
                        r_byte_ready <= 1'b1;
                        r_loaded     <= 1'b0;
                        r_in_open    <= 1'b0;
                    end else if (in_valid) begin
                        r_state         <= ST_EVAL;
                        r_neuron_inputs <= in_data;
                        r_in_open       <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    r_state     <= ST_LOADED;
                    r_out_data  <= axons;
                    r_out_valid <= 1'b1;
                    r_in_open   <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_setup      <= 1'b0;
                    r_loaded     <= 1'b0;
                    r_in_open    <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready    = r_byte_ready;
    assign setup         = r_setup;
    assign param_bit     = r_setup & w_bit;
    assign loaded        = r_loaded;
    assign in_ready      = r_in_open & ~start_load;
    assign neuron_inputs = r_neuron_inputs;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Self-checking bench for bnn_param_loader with a behavioural neuron chain and reference model.
module tb_bnn_param_loader;

    localparam int N  = 4;
    localparam int I  = 8;
    localparam int B  = 3;
    localparam int PB = I + B;
    localparam int CB = N * PB;
    localparam int NB = (CB + 7) / 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_load;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         setup;
    logic         param_bit;
    logic         loaded;
    logic         in_valid;
    logic         in_ready;
    logic [I-1:0] in_data;
    logic [I-1:0] neuron_inputs;
    logic [N-1:0] axons;
    logic         out_valid;
    logic [N-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]    ld_bytes [NB];
    logic [CB-1:0] exp_chain;
    logic [CB-1:0] env_chain;
    logic [I-1:0]  last_vec;

    bnn_param_loader #(.NEURONS(N), .INPUTS(I), .BIAS_BITS(B)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .setup(setup), .param_bit(param_bit),
        .loaded(loaded), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .neuron_inputs(neuron_inputs), .axons(axons), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Neuron: fires when the number of input bits matching its weights exceeds its bias.
    function automatic logic neuron_fire(input logic [PB-1:0] p, input logic [I-1:0] v);
        logic [I-1:0] w;
        logic [B-1:0] b;
        w = p[PB-1:B];
        b = p[B-1:0];
        return $countones(~(w ^ v)) > int'(b);
    endfunction

    always_ff @(posedge clk) begin
        if (setup) env_chain <= {env_chain[CB-2:0], param_bit};
    end

    always_comb begin
        axons = '0;
        for (int k = 0; k < N; k++) axons[k] = neuron_fire(env_chain[k*PB +: PB], neuron_inputs);
    end

    function automatic logic stream_bit(input int i);
        logic [7:0] b;
        b = ld_bytes[i / 8];
        return b[7 - (i % 8)];
    endfunction

    function automatic logic [N-1:0] model_out(input logic [I-1:0] v);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = neuron_fire(exp_chain[k*PB +: PB], v);
        return r;
    endfunction

    task automatic do_load(input string name, input bit do_start, input int gap_lo, input int gap_hi,
                           input int start_at, input int abort_after);
        int idx = 0;
        int gap_cnt = 0;
        int setup_cnt = 0;
        int viol = 0;
        int cyc = 0;
        bit hs;
        logic [CB-1:0] got;
        logic [CB-1:0] expv;
        got = '0;
        if (do_start) begin
            start_load = 1'b1;
            @(posedge clk); #1;
            start_load = 1'b0;
        end
        while (loaded !== 1'b1 && cyc < 800) begin
            byte_valid = (gap_cnt == 0) && (idx < NB);
            byte_data  = (idx < NB) ? ld_bytes[idx] : 8'h00;
            start_load = (cyc == start_at);
            in_valid   = 1'($urandom_range(1, 0));
            in_data    = I'($urandom);
            @(negedge clk);
            if (setup === 1'b1) begin
                if (setup_cnt < CB) got[CB-1-setup_cnt] = param_bit;
                setup_cnt++;
            end
            if (setup === 1'b1 && byte_ready === 1'b1) viol++;
            if (in_ready !== 1'b0) viol++;
            hs = byte_valid && (byte_ready === 1'b1);
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                gap_cnt = $urandom_range(gap_hi, gap_lo);
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            cyc++;
            if (abort_after > 0 && setup_cnt == abort_after) break;
        end
        byte_valid = 1'b0;
        start_load = 1'b0;
        in_valid   = 1'b0;
        if (abort_after > 0) return;
        for (int i = 0; i < CB; i++) expv[CB-1-i] = stream_bit(i);
        exp_chain = expv;
        n_cmp++;
        if (loaded !== 1'b1) begin
            n_bad++; $display("FAIL %s loaded: got %b want 1 after %0d cycles", name, loaded, cyc);
        end
        n_cmp++;
        if (setup_cnt != CB) begin
            n_bad++; $display("FAIL %s setup_cycles: got %0d want %0d", name, setup_cnt, CB);
        end
        n_cmp++;
        if (got !== expv) begin
            n_bad++; $display("FAIL %s bit_sequence: got %h want %h", name, got, expv);
        end
        n_cmp++;
        if (viol != 0) begin
            n_bad++; $display("FAIL %s handshake_rules: got %0d violations want 0", name, viol);
        end
        n_cmp++;
        if ({setup, param_bit, byte_ready, neuron_inputs} !== {3'b000, last_vec}) begin
            n_bad++; $display("FAIL %s post_load_outputs: got %b/%b/%b/%h want 0/0/0/%h",
                              name, setup, param_bit, byte_ready, neuron_inputs, last_vec);
        end
    endtask

    task automatic run_infer(input string name, input logic [I-1:0] vec, input logic [N-1:0] expd);
        in_valid = 1'b1;
        in_data  = vec;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_data = ~vec;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, neuron_inputs} !== {2'b00, vec}) begin
            n_bad++; $display("FAIL %s eval_cycle: got rdy=%b ov=%b ni=%h want 0 0 %h",
                              name, in_ready, out_valid, neuron_inputs, vec);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_data, neuron_inputs} !== {1'b1, expd, vec}) begin
            n_bad++; $display("FAIL %s result: got ov=%b od=%h ni=%h want 1 %h %h",
                              name, out_valid, out_data, neuron_inputs, expd, vec);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_data} !== {1'b0, expd}) begin
            n_bad++; $display("FAIL %s hold: got ov=%b od=%h want 0 %h", name, out_valid, out_data, expd);
        end
        @(posedge clk); #1;
        last_vec = vec;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_load = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; in_valid = 1'b0; in_data = '0;
        last_vec = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({byte_ready, setup, param_bit, loaded, in_ready, out_valid, neuron_inputs, out_data} !== '0) begin
            n_bad++; $display("FAIL reset_state: got %b%b%b%b%b%b %h %h want all zero", byte_ready, setup,
                              param_bit, loaded, in_ready, out_valid, neuron_inputs, out_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_bytes(input logic [8*NB-1:0] s);
        for (int j = 0; j < NB; j++) ld_bytes[j] = s[8*NB-1-8*j -: 8];
    endtask

    task automatic test_load_basic();
        set_bytes(48'hA5_3C_FF_00_81_F0);
        do_load("load_basic", 1'b1, 0, 0, -1, 0);
    endtask

    task automatic test_load_gaps();
        set_bytes(48'hA5_3C_FF_00_81_F0);
        do_load("load_gaps", 1'b1, 3, 3, -1, 0);
    endtask

    task automatic test_inference_known();
        logic [PB-1:0] p;
        logic [8*NB-1:0] s;
        p = 11'b11111111_011;
        s = {p, p, p, p, 4'b0000};
        set_bytes(s);
        do_load("load_ones", 1'b1, 0, 2, -1, 0);
        run_infer("infer_ff", 8'hFF, 4'hF);
        run_infer("infer_07", 8'h07, 4'h0);
        run_infer("infer_0f", 8'h0F, 4'hF);
    endtask

    task automatic test_start_vs_in_valid();
        int seen_ov = 0;
        start_load = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL start_wins in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        start_load = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({byte_ready, loaded} !== 2'b10) begin
            n_bad++; $display("FAIL start_wins state: got rdy=%b loaded=%b want 1 0", byte_ready, loaded);
        end
        for (int c = 0; c < 3; c++) begin
            if (out_valid !== 1'b0) seen_ov++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_ov != 0) begin
            n_bad++; $display("FAIL start_wins out_valid: got %0d pulses want 0", seen_ov);
        end
        @(posedge clk); #1;
        do_load("start_wins_reload", 1'b0, 0, 1, -1, 0);
        run_infer("start_wins_infer", 8'h33, model_out(8'h33));
    endtask

    task automatic test_reset_mid_load();
        for (int j = 0; j < NB; j++) ld_bytes[j] = 8'($urandom);
        do_load("abort", 1'b1, 0, 0, -1, 20);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({byte_ready, setup, param_bit, loaded, in_ready, out_valid, neuron_inputs, out_data} !== '0) begin
            n_bad++; $display("FAIL reset_mid_load: got %b%b%b%b%b%b %h %h want all zero", byte_ready, setup,
                              param_bit, loaded, in_ready, out_valid, neuron_inputs, out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        last_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (loaded !== 1'b0) begin
            n_bad++; $display("FAIL reset_loaded: got %b want 0", loaded);
        end
        do_load("reload_after_reset", 1'b1, 0, 0, -1, 0);
    endtask

    task automatic test_start_during_shift();
        for (int j = 0; j < NB; j++) ld_bytes[j] = 8'($urandom);
        do_load("start_in_shift", 1'b1, 0, 0, 12, 0);
    endtask

    task automatic test_random();
        logic [I-1:0] v;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < NB; j++) ld_bytes[j] = 8'($urandom);
            do_load($sformatf("rand_load%0d", r), 1'b1, 0, 4, -1, 0);
            for (int t = 0; t < 5; t++) begin
                v = I'($urandom);
                repeat ($urandom_range(2, 0)) @(posedge clk);
                #1;
                run_infer($sformatf("rand_infer%0d_%0d", r, t), v, model_out(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_inference_known();
        test_start_vs_in_valid();
        test_reset_mid_load();
        test_start_during_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
